// File: rtl/washing_machine_multi.sv
// washing_machine_multi
//   Washer cycle controller with an integrated prescaled seconds timer.
//   A cycle is bought with PRICE coins in IDLE, then runs
//   FILL -> (WASH -> RINSE) x N -> SPIN -> DONE -> IDLE, where N is the
//   clamped repeat_sel value latched at start. Every phase lasts its
//   *_SEC parameter in one-second ticks of TICK_DIV clocks each.
//
// Ports
//   CLK          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   coin_in      in   one coin per sampled-high cycle, counted in IDLE only
//   repeat_sel   in   requested wash/rinse passes (0 -> 1, >MAX -> MAX)
//   timer_pause  in   freezes prescaler and seconds during SPIN only
//   abort        in   cancels cycle or credit, back to IDLE next cycle
//   wash_done    out  one-cycle pulse while in DONE
//   state_op     out  state code (IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DONE=5)
//   pass_cnt     out  current pass, 1-based; 0 in IDLE
//   sec_left     out  seconds remaining in the current phase
//   credit       out  coins collected so far in IDLE
module washing_machine_multi #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned FILL_SEC   = 120,
  parameter int unsigned WASH_SEC   = 300,
  parameter int unsigned RINSE_SEC  = 120,
  parameter int unsigned SPIN_SEC   = 60,
  parameter int unsigned PRICE      = 2,
  parameter int unsigned MAX_REPEAT = 3,
  parameter int unsigned SEC_W      = 10,
  localparam int unsigned REP_W     = $clog2(MAX_REPEAT + 1),
  localparam int unsigned CR_W      = $clog2(PRICE + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             coin_in,
  input  logic [REP_W-1:0] repeat_sel,
  input  logic             timer_pause,
  input  logic             abort,
  output logic             wash_done,
  output logic [2:0]       state_op,
  output logic [REP_W-1:0] pass_cnt,
  output logic [SEC_W-1:0] sec_left,
  output logic [CR_W-1:0]  credit
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PS_W-1:0]  PS_MAX    = PS_W'(TICK_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX   = REP_W'(MAX_REPEAT);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
  localparam logic [CR_W-1:0]  CR_PRICE  = CR_W'(PRICE);
  localparam logic [CR_W-1:0]  CR_START  = CR_W'(PRICE - 1);
  localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);
  localparam logic [SEC_W-1:0] SEC_FILL  = SEC_W'(FILL_SEC);
  localparam logic [SEC_W-1:0] SEC_WASH  = SEC_W'(WASH_SEC);
  localparam logic [SEC_W-1:0] SEC_RINSE = SEC_W'(RINSE_SEC);
  localparam logic [SEC_W-1:0] SEC_SPIN  = SEC_W'(SPIN_SEC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  logic [PS_W-1:0]  r_presc;
  logic [SEC_W-1:0] r_sec;
  logic [REP_W-1:0] r_pass;
  logic [REP_W-1:0] r_rep;
  logic [CR_W-1:0]  r_credit;
  logic             r_done;

  logic             w_tick;
  logic             w_run;
  logic             w_expire;
  logic [REP_W-1:0] w_rep_clamped;

  always_comb begin
    w_tick = (r_presc == PS_MAX);
    // Timer advances in every timed phase; pause only has an effect in SPIN.
    w_run  = (r_state == S_FILL) || (r_state == S_WASH) || (r_state == S_RINSE) ||
             ((r_state == S_SPIN) && !timer_pause);
    w_expire = w_run && w_tick && (r_sec == SEC_ONE);

    if (repeat_sel == '0) begin
      w_rep_clamped = REP_ONE;
    end else if (repeat_sel > REP_MAX) begin
      w_rep_clamped = REP_MAX;
    end else begin
      w_rep_clamped = repeat_sel;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_sec    <= '0;
      r_pass   <= '0;
      r_rep    <= REP_ONE;
      r_credit <= '0;
      r_done   <= 1'b0;
    end else if (abort) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_sec    <= '0;
      r_pass   <= '0;
      r_credit <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          r_sec   <= '0;
          r_pass  <= '0;
          if (coin_in) begin
            if (r_credit == CR_START) begin
              r_state  <= S_FILL;
              r_credit <= '0;
              r_sec    <= SEC_FILL;
              r_rep    <= w_rep_clamped;
            end else if (r_credit < CR_PRICE) begin
              r_credit <= r_credit + 1'b1;
            end
          end
        end

        S_FILL, S_WASH, S_RINSE, S_SPIN: begin
          if (w_run) begin
            if (w_tick) begin
              r_presc <= '0;
              r_sec   <= r_sec - 1'b1;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          // Expiry loads the next phase's duration over the decrement above;
          // the prescaler has already wrapped to 0 on this tick.
          if (w_expire) begin
            case (r_state)
              S_FILL: begin
                r_state <= S_WASH;
                r_sec   <= SEC_WASH;
                r_pass  <= REP_ONE;
              end
              S_WASH: begin
                r_state <= S_RINSE;
                r_sec   <= SEC_RINSE;
              end
              S_RINSE: begin
                if (r_pass < r_rep) begin
                  r_state <= S_WASH;
                  r_sec   <= SEC_WASH;
                  r_pass  <= r_pass + 1'b1;
                end else begin
                  r_state <= S_SPIN;
                  r_sec   <= SEC_SPIN;
                end
              end
              S_SPIN: begin
                r_state <= S_DONE;
                r_sec   <= '0;
                r_done  <= 1'b1;
              end
              default: begin
                r_state <= S_IDLE;
              end
            endcase
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_presc <= '0;
          r_sec   <= '0;
          r_pass  <= '0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_presc  <= '0;
          r_sec    <= '0;
          r_pass   <= '0;
          r_credit <= '0;
        end
      endcase
    end
  end

  assign wash_done = r_done;
  assign state_op  = r_state;
  assign pass_cnt  = r_pass;
  assign sec_left  = r_sec;
  assign credit    = r_credit;

endmodule

// File: tb/tb_washing_machine_multi.sv
// tb_washing_machine_multi
//   Bench for washing_machine_multi with a short timebase. Each queue record
//   holds the inputs applied before one rising edge and the outputs expected
//   right after it; whole wash cycles are described by a small scenario table
//   and expanded into records from the phase durations.
module tb_washing_machine_multi;

  localparam int unsigned TICK  = 2;
  localparam int unsigned FSEC  = 2;
  localparam int unsigned WSEC  = 3;
  localparam int unsigned RSEC  = 2;
  localparam int unsigned SSEC  = 2;
  localparam int unsigned PRICE = 2;
  localparam int unsigned MAXR  = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_WASH  = 3'd2;
  localparam logic [2:0] ST_RINSE = 3'd3;
  localparam logic [2:0] ST_SPIN  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic       CLK = 1'b0;
  logic       rst;
  logic       coin_in;
  logic [1:0] repeat_sel;
  logic       timer_pause;
  logic       abort;
  logic       wash_done;
  logic [2:0] state_op;
  logic [1:0] pass_cnt;
  logic [9:0] sec_left;
  logic [1:0] credit;

  washing_machine_multi #(
    .TICK_DIV   (TICK),
    .FILL_SEC   (FSEC),
    .WASH_SEC   (WSEC),
    .RINSE_SEC  (RSEC),
    .SPIN_SEC   (SSEC),
    .PRICE      (PRICE),
    .MAX_REPEAT (MAXR),
    .SEC_W      (10)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .coin_in     (coin_in),
    .repeat_sel  (repeat_sel),
    .timer_pause (timer_pause),
    .abort       (abort),
    .wash_done   (wash_done),
    .state_op    (state_op),
    .pass_cnt    (pass_cnt),
    .sec_left    (sec_left),
    .credit      (credit)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       coin;
    logic       abt;
    logic       pause;
    logic [1:0] rsel;
    logic [2:0] st;
    logic [1:0] pass;
    logic [9:0] sec;
    logic [1:0] cr;
    logic       done;
  } vec_t;

  typedef struct {
    logic [1:0]  rsel;
    int unsigned passes;
    bit          fill_pause;
    int unsigned spin_pause;
    bit          coin_wash;
  } scen_t;

  vec_t        sb[$];
  scen_t       tbl[5];
  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;
  int unsigned vec_no    = 0;
  int unsigned pz        = 0;
  bit          coin_wash = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, vec_no, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic a, input logic p, input logic [1:0] rs,
                     input logic [2:0] st, input int unsigned pass, input int unsigned sec,
                     input int unsigned cr, input logic d);
    vec_t v;
    v.coin  = c;
    v.abt   = a;
    v.pause = p;
    v.rsel  = rs;
    v.st    = st;
    v.pass  = 2'(pass);
    v.sec   = 10'(sec);
    v.cr    = 2'(cr);
    v.done  = d;
    sb.push_back(v);
  endtask

  function automatic logic take_pause();
    if (pz != 0) begin
      pz--;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Records for one timed phase from position 'first' onward: each second
  // value is visible for TICK consecutive cycles, counting down to 1.
  task automatic push_phase(input logic [2:0] st, input int unsigned secs,
                            input int unsigned pass, input logic [1:0] rs,
                            input int unsigned first);
    for (int unsigned i = first; i < TICK * secs; i++) begin
      logic c;
      logic p;
      c = coin_wash && (st == ST_WASH);
      p = take_pause();
      add(c, 1'b0, p, rs, st, pass, secs - i / TICK, 0, 1'b0);
    end
  endtask

  task automatic build_start(input logic [1:0] rsel, input logic [1:0] rs_mid);
    add(1'b1, 1'b0, 1'b0, rsel, ST_IDLE, 0, 0, 1, 1'b0);
    add(1'b0, 1'b0, 1'b0, rsel, ST_IDLE, 0, 0, 1, 1'b0);
    add(1'b1, 1'b0, 1'b0, rsel, ST_FILL, 0, FSEC, 0, 1'b0);
    push_phase(ST_FILL, FSEC, 0, rs_mid, 1);
  endtask

  task automatic build_finish(input int unsigned passes, input int unsigned spin_pause,
                              input logic [1:0] rs);
    for (int unsigned i = 0; i < TICK * SSEC; i++) begin
      add(1'b0, 1'b0, 1'b0, rs, ST_SPIN, passes, SSEC - i / TICK, 0, 1'b0);
      if (i == 1) begin
        for (int unsigned k = 0; k < spin_pause; k++)
          add(1'b0, 1'b0, 1'b1, rs, ST_SPIN, passes, SSEC - i / TICK, 0, 1'b0);
      end
    end
    add(1'b0, 1'b0, 1'b0, rs, ST_DONE, passes, 0, 0, 1'b1);
    add(1'b0, 1'b0, 1'b0, rs, ST_IDLE, 0, 0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, rs, ST_IDLE, 0, 0, 0, 1'b0);
  endtask

  task automatic build_cycle(input logic [1:0] rsel, input int unsigned passes,
                             input int unsigned spin_pause);
    logic [1:0] rs_mid;
    rs_mid = rsel ^ 2'b11;
    build_start(rsel, rs_mid);
    for (int unsigned p = 1; p <= passes; p++) begin
      push_phase(ST_WASH, WSEC, p, rs_mid, 0);
      push_phase(ST_RINSE, RSEC, p, rs_mid, 0);
    end
    build_finish(passes, spin_pause, rs_mid);
  endtask

  task automatic run_queue();
    vec_t v;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge CLK);
      coin_in     = v.coin;
      abort       = v.abt;
      timer_pause = v.pause;
      repeat_sel  = v.rsel;
      @(posedge CLK);
      #1;
      check("state_op",  32'(state_op),  32'(v.st));
      check("pass_cnt",  32'(pass_cnt),  32'(v.pass));
      check("sec_left",  32'(sec_left),  32'(v.sec));
      check("credit",    32'(credit),    32'(v.cr));
      check("wash_done", 32'(wash_done), 32'(v.done));
      vec_no++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state_op),  32'(ST_IDLE));
    check({tag, "_pass"},  32'(pass_cnt),  32'd0);
    check({tag, "_sec"},   32'(sec_left),  32'd0);
    check({tag, "_credit"},32'(credit),    32'd0);
    check({tag, "_done"},  32'(wash_done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rsel, passes, fill_pause, spin_pause, coin_wash
    tbl[0] = '{2'd2,   2, 1'b0, 0, 1'b0};
    tbl[1] = '{2'd0,   1, 1'b0, 0, 1'b0};
    tbl[2] = '{2'(7),  3, 1'b0, 0, 1'b0};
    tbl[3] = '{2'd1,   1, 1'b1, 5, 1'b0};
    tbl[4] = '{2'd1,   1, 1'b0, 0, 1'b1};

    rst = 1'b1;
    coin_in = 1'b0;
    abort = 1'b0;
    timer_pause = 1'b0;
    repeat_sel = 2'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      coin_wash = tbl[i].coin_wash;
      pz = tbl[i].fill_pause ? 5 : 0;
      build_cycle(tbl[i].rsel, tbl[i].passes, tbl[i].spin_pause);
      run_queue();
    end
    coin_wash = 1'b0;
    pz = 0;

    // Credit handling in IDLE: abort clears credit, abort beats coin and start.
    add(1'b1, 1'b0, 1'b0, 2'd1, ST_IDLE, 0, 0, 1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'd1, ST_IDLE, 0, 0, 0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'd1, ST_IDLE, 0, 0, 0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 2'd1, ST_IDLE, 0, 0, 1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'd1, ST_IDLE, 0, 0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'd1, ST_IDLE, 0, 0, 0, 1'b0);
    run_queue();

    // Abort on the edge where WASH of pass 2 would expire.
    build_start(2'd2, 2'd2);
    push_phase(ST_WASH, WSEC, 1, 2'd2, 0);
    push_phase(ST_RINSE, RSEC, 1, 2'd2, 0);
    push_phase(ST_WASH, WSEC, 2, 2'd2, 0);
    add(1'b0, 1'b1, 1'b0, 2'd2, ST_IDLE, 0, 0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'd2, ST_IDLE, 0, 0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'd2, ST_IDLE, 0, 0, 0, 1'b0);
    run_queue();

    // Asynchronous reset between edges in the middle of RINSE.
    build_start(2'd2, 2'd2);
    push_phase(ST_WASH, WSEC, 1, 2'd2, 0);
    add(1'b0, 1'b0, 1'b0, 2'd2, ST_RINSE, 1, RSEC, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'd2, ST_RINSE, 1, RSEC, 0, 1'b0);
    run_queue();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge CLK);
    rst = 1'b0;
    build_cycle(2'd2, 2, 0);
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/washing_machine_multi.md
Name: washing_machine_multi

Overview:
- Parametrised next-generation washing machine controller: one FSM with an integrated prescaled seconds timer.
- Adds over the current controller:
  - coin credit accumulation up to a configurable price
  - a per-cycle selectable number of wash/rinse passes
  - per-phase durations set by parameters
  - an abort input
  - live status outputs for pass number, seconds remaining and credit.
- Sits at the top of the washer datapath and drives the panel/status logic.

Parameters:
- TICK_DIV, 50000000: CLK cycles per one-second tick (>=1).
- FILL_SEC, 120: fill phase duration in seconds (>=1).
- WASH_SEC, 300: wash phase duration in seconds (>=1).
- RINSE_SEC, 120: rinse phase duration in seconds (>=1).
- SPIN_SEC, 60: spin phase duration in seconds (>=1).
- PRICE, 2: coins required to start a cycle (>=1).
- MAX_REPEAT, 3: maximum wash+rinse passes (>=1).
- SEC_W, 10: sec_left width; must hold the largest *_SEC value.
- Derived localparams: REP_W = clog2(MAX_REPEAT+1), CR_W = clog2(PRICE+1).

Ports:
- CLK, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- coin_in, input, 1: one coin per cycle sampled high; only counted in IDLE.
- repeat_sel, input, REP_W: number of passes, latched on start. 0 is treated as 1; values >MAX_REPEAT clamp to MAX_REPEAT.
- timer_pause, input, 1: freezes the timer during SPIN only.
- abort, input, 1: cancels the cycle or credit; returns to IDLE.
- wash_done, output, 1: single-cycle pulse on normal completion.
- state_op, output, 3: current state encoding.
- pass_cnt, output, REP_W: current pass (1-based) in WASH/RINSE; held through SPIN; 0 in IDLE.
- sec_left, output, SEC_W: seconds remaining in the current phase; 0 in IDLE/DONE.
- credit, output, CR_W: coins accumulated in IDLE.

Behaviour:
- Reset:
  - rst high asynchronously forces state IDLE.
  - Outputs: wash_done=0, pass_cnt=0, sec_left=0, credit=0. Prescaler=0; latched repeat count=1.
- State encoding: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5. Codes 6/7 are illegal and recover to IDLE next cycle.
- All outputs are registered.
- Prescaler and tick:
  - Prescaler counts 0..TICK_DIV-1 in FILL/WASH/RINSE/SPIN.
  - Cleared to 0 on every phase entry.
  - tick = (prescaler==TICK_DIV-1).
  - On tick, sec_left decrements.
  - Each phase therefore occupies exactly SEC*TICK_DIV cycles when unpaused.
- Phase exit: a tick with sec_left==1 ends the phase. The next state's duration is loaded into sec_left on the same edge.
- IDLE:
  - coin_in high: credit increments, saturating at PRICE.
  - When coin_in is high with credit==PRICE-1: next cycle state=FILL, credit=0, sec_left=FILL_SEC, repeat count latched from the clamped repeat_sel.
  - PRICE=1 means a single coin starts the cycle.
- FILL -> WASH on expiry. Load WASH_SEC; pass_cnt=1.
- WASH -> RINSE on expiry. Load RINSE_SEC.
- RINSE on expiry:
  - If pass_cnt < latched count: -> WASH, pass_cnt+1, load WASH_SEC.
  - Else: -> SPIN, load SPIN_SEC.
- SPIN:
  - While timer_pause is high, prescaler and sec_left hold.
  - On expiry -> DONE.
  - timer_pause is ignored in every other state.
- DONE:
  - wash_done=1 for exactly this one cycle.
  - Next cycle -> IDLE, pass_cnt=0, sec_left=0.
- coin_in outside IDLE is ignored: no credit, no refund.
- abort:
  - Highest priority below rst, in any state.
  - Next cycle: state=IDLE, credit=0, pass_cnt=0, sec_left=0, prescaler=0, wash_done=0.
  - Beats a simultaneous phase expiry, coin, or start condition.
- repeat_sel changes mid-cycle have no effect; only the start-time latch is used.
- rst asserted mid-operation aborts immediately; no wash_done pulse.

Test Plan:
All scenarios use TICK_DIV=2, FILL_SEC=2, WASH_SEC=3, RINSE_SEC=2, SPIN_SEC=2, PRICE=2, MAX_REPEAT=3.
1. Full cycle, repeat_sel=2: two single-cycle coin pulses.
   - Credit goes 1 then FILL; states FILL(4 cycles), WASH(6), RINSE(4), WASH(6), RINSE(4), SPIN(4).
   - pass_cnt is 1 then 2; wash_done high exactly 1 cycle, 28 cycles after FILL entry; then IDLE.
2. repeat_sel=0 and repeat_sel=7:
   - 0 gives one WASH/RINSE pass.
   - 7 gives three passes (pass_cnt reaches 3, never 4).
3. Pause: hold timer_pause for 5 cycles during FILL, then 5 cycles mid-SPIN.
   - FILL length is unchanged at 4.
   - SPIN lasts 9 cycles; sec_left is frozen during the pause.
4. Coins: one coin then abort.
   - credit=1 then 0, state remains IDLE.
   - Coins during WASH leave credit=0.
   - coin and abort in the same IDLE cycle give credit=0.
5. Abort in WASH, pass 2, coincident with phase expiry: next cycle IDLE; pass_cnt=0, sec_left=0, no wash_done.
6. Async rst pulse mid-RINSE, between clock edges: outputs go 0 and state IDLE before the next edge; a new 2-coin start then runs normally.
